// File: rtl/game_score_keeper_if.sv
// Bus between the game-logic controller (master) and the score keeper (slave):
// move/coin events, purchase handshake and the score/coin results for display.
interface game_score_keeper_if;
  logic [2:0]  game_state;
  logic        step_fwd;
  logic        step_back;
  logic        coin_pick;
  logic        buy_req;
  logic [9:0]  cost;
  logic        buy_ack;
  logic        buy_nack;
  logic [9:0]  score;
  logic [9:0]  coin;
  logic [9:0]  best;
  logic [9:0]  coin_store;
  logic [11:0] score_bcd;
  logic        bcd_valid;

  modport master (
    output game_state, step_fwd, step_back, coin_pick, buy_req, cost,
    input  buy_ack, buy_nack, score, coin, best, coin_store, score_bcd, bcd_valid
  );

  modport slave (
    input  game_state, step_fwd, step_back, coin_pick, buy_req, cost,
    output buy_ack, buy_nack, score, coin, best, coin_store, score_bcd, bcd_valid
  );
endinterface

// File: rtl/game_score_keeper.sv
// Run score/coin bookkeeping, best score, coin bank with purchase arbitration,
// and a serial double-dabble converter that presents the score as BCD.
module game_score_keeper #(
  parameter int unsigned SCORE_MAX = 999,
  parameter int unsigned COIN_MAX  = 999
) (
  input logic               clk,
  input logic               rst,
  game_score_keeper_if.slave bus
);
  localparam int unsigned W      = 10;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned CNT_W  = 4;
  localparam logic [W-1:0] SCORE_LIM = W'(SCORE_MAX);
  localparam logic [W-1:0] COIN_LIM  = W'(COIN_MAX);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  typedef enum logic {BUY_IDLE, BUY_DONE} buy_state_t;
  typedef enum logic {BCD_IDLE, BCD_SHIFT} bcd_state_t;

  logic [2:0]   prev_state;
  logic [W-1:0] pos, score_q, coin_q, best_q, store_q;
  logic         run_start, death, playing, menu;
  logic         fwd_only, back_only;
  logic [W-1:0] pos_inc;
  logic [W:0]   bank_sum;

  assign playing   = (bus.game_state == 3'd1);
  assign menu      = (bus.game_state == 3'd0) || (bus.game_state >= 3'd3);
  assign run_start = (prev_state != 3'd1) && playing;
  assign death     = (prev_state != 3'd2) && (bus.game_state == 3'd2);
  assign fwd_only  = bus.step_fwd && !bus.step_back;
  assign back_only = bus.step_back && !bus.step_fwd;
  assign pos_inc   = (pos < SCORE_LIM) ? pos + W'(1) : pos;
  assign bank_sum  = {1'b0, store_q} + {1'b0, coin_q};

  // Purchase FSM: one grant or refusal per request, serviced only from the menu
  buy_state_t buy_state, buy_state_n;
  logic       ack_n, nack_n, debit;
  logic       ack_q, nack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buy_state <= BUY_IDLE;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      buy_state <= buy_state_n;
      ack_q     <= ack_n;
      nack_q    <= nack_n;
    end
  end

  always_comb begin
    buy_state_n = buy_state;
    ack_n       = 1'b0;
    nack_n      = 1'b0;
    debit       = 1'b0;
    case (buy_state)
      BUY_IDLE: begin
        if (menu && bus.buy_req) begin
          if (store_q >= bus.cost) begin
            ack_n = 1'b1;
            debit = 1'b1;
          end else begin
            nack_n = 1'b1;
          end
          buy_state_n = BUY_DONE;
        end
      end
      BUY_DONE: begin
        if (!bus.buy_req) buy_state_n = BUY_IDLE;
      end
      default: buy_state_n = BUY_IDLE;
    endcase
  end

  // Run tracking, death credit and purchase debit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= 3'd0;
      pos        <= '0;
      score_q    <= '0;
      coin_q     <= '0;
      best_q     <= '0;
      store_q    <= '0;
    end else begin
      prev_state <= bus.game_state;
      if (run_start) begin
        pos     <= '0;
        score_q <= '0;
        coin_q  <= '0;
      end else if (playing) begin
        if (fwd_only) begin
          pos <= pos_inc;
          if (pos_inc > score_q) score_q <= pos_inc;
        end else if (back_only && (pos != '0)) begin
          pos <= pos - W'(1);
        end
        if (bus.coin_pick && (coin_q < COIN_LIM)) coin_q <= coin_q + W'(1);
      end
      if (death) begin
        if (score_q > best_q) best_q <= score_q;
        store_q <= (bank_sum > {1'b0, COIN_LIM}) ? COIN_LIM : bank_sum[W-1:0];
      end else if (debit) begin
        store_q <= store_q - bus.cost;
      end
    end
  end

  // BCD converter: snapshot the score, then one double-dabble step per cycle
  bcd_state_t       bcd_state, bcd_state_n;
  logic [W-1:0]     snap, snap_n, bin, bin_n;
  logic [BCD_W-1:0] acc, acc_n, adj, bcd_q, bcd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             valid_q, valid_n;
  logic [BCD_W+W-1:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_state <= BCD_IDLE;
      snap      <= '0;
      bin       <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b1;
    end else begin
      bcd_state <= bcd_state_n;
      snap      <= snap_n;
      bin       <= bin_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      bcd_q     <= bcd_n;
      valid_q   <= valid_n;
    end
  end

  always_comb begin
    bcd_state_n = bcd_state;
    snap_n      = snap;
    bin_n       = bin;
    acc_n       = acc;
    cnt_n       = cnt;
    bcd_n       = bcd_q;
    valid_n     = valid_q;
    adj         = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    shifted     = {adj, bin} << 1;
    case (bcd_state)
      BCD_IDLE: begin
        if (score_q != snap) begin
          snap_n      = score_q;
          bin_n       = score_q;
          acc_n       = '0;
          cnt_n       = '0;
          valid_n     = 1'b0;
          bcd_state_n = BCD_SHIFT;
        end
      end
      BCD_SHIFT: begin
        acc_n = shifted[BCD_W+W-1:W];
        bin_n = shifted[W-1:0];
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          bcd_n       = shifted[BCD_W+W-1:W];
          valid_n     = (score_q == snap);
          bcd_state_n = BCD_IDLE;
        end
      end
      default: bcd_state_n = BCD_IDLE;
    endcase
  end

  assign bus.buy_ack    = ack_q;
  assign bus.buy_nack   = nack_q;
  assign bus.score      = score_q;
  assign bus.coin       = coin_q;
  assign bus.best       = best_q;
  assign bus.coin_store = store_q;
  assign bus.score_bcd  = bcd_q;
  assign bus.bcd_valid  = valid_q;
endmodule

// File: tb/tb_game_score_keeper.sv
// Directed bench for game_score_keeper: purchase results and BCD completions
// are checked by monitors against queued expectations; run state is checked inline.
module tb_game_score_keeper;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_score_keeper_if bus();

  game_score_keeper #(.SCORE_MAX(999), .COIN_MAX(999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       ack;
    logic [9:0] store;
  } buy_exp_t;

  buy_exp_t    buy_q[$];
  logic [11:0] bcd_q[$];
  int checks = 0;
  int fails  = 0;
  int m_pos  = 0;
  int m_score = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fwd_step();
    bus.step_fwd = 1'b1;
    tick();
    bus.step_fwd = 1'b0;
    m_pos = (m_pos < 999) ? m_pos + 1 : 999;
    if (m_pos > m_score) begin
      m_score = m_pos;
      bcd_q.push_back(to_bcd(m_score));
    end
  endtask

  task automatic back_step();
    bus.step_back = 1'b1;
    tick();
    bus.step_back = 1'b0;
    m_pos = (m_pos > 0) ? m_pos - 1 : 0;
  endtask

  task automatic buy(input logic [9:0] c, input int hold);
    bus.cost    = c;
    bus.buy_req = 1'b1;
    idle(hold);
    bus.buy_req = 1'b0;
    idle(3);
  endtask

  // Purchase monitor
  initial begin
    buy_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.buy_ack || bus.buy_nack)) begin
        if (buy_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL buy_unexpected: ack=%0b nack=%0b, expected no pulse (t=%0t)",
                   bus.buy_ack, bus.buy_nack, $time);
        end else begin
          e = buy_q.pop_front();
          chk("buy_ack", 32'(bus.buy_ack), 32'(e.ack));
          chk("buy_nack", 32'(bus.buy_nack), 32'(!e.ack));
          chk("buy_store", 32'(bus.coin_store), 32'(e.store));
        end
      end
    end
  end

  // BCD completion monitor: each rise of bcd_valid consumes one expected value
  initial begin
    logic prev_v;
    logic [11:0] e;
    prev_v = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b1;
      end else begin
        if (bus.bcd_valid && !prev_v) begin
          if (bcd_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL bcd_unexpected: score_bcd=%0h, expected no completion (t=%0t)",
                     bus.score_bcd, $time);
          end else begin
            e = bcd_q.pop_front();
            chk("bcd_result", 32'(bus.score_bcd), 32'(e));
          end
        end
        prev_v = bus.bcd_valid;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.game_state = 3'd0;
    bus.step_fwd   = 1'b0;
    bus.step_back  = 1'b0;
    bus.coin_pick  = 1'b0;
    bus.buy_req    = 1'b0;
    bus.cost       = 10'd0;
    idle(3);
    rst = 1'b0;
    tick();

    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_coin", 32'(bus.coin), 32'd0);
    chk("rst_best", 32'(bus.best), 32'd0);
    chk("rst_store", 32'(bus.coin_store), 32'd0);
    chk("rst_bcd", 32'(bus.score_bcd), 32'h000);
    chk("rst_bcd_valid", 32'(bus.bcd_valid), 32'd1);
    chk("rst_ack", 32'(bus.buy_ack), 32'd0);
    chk("rst_nack", 32'(bus.buy_nack), 32'd0);

    // Run: fwd x5, back x2, fwd x1 -> pos 4, score 5
    bus.game_state = 3'd1;
    tick();
    repeat (4) begin fwd_step(); idle(12); end
    fwd_step();
    chk("score_after_5fwd", 32'(bus.score), 32'd5);
    idle(10);
    chk("bcd_valid_low_10cyc", 32'(bus.bcd_valid), 32'd0);
    tick();
    chk("bcd_valid_11cyc", 32'(bus.bcd_valid), 32'd1);
    chk("bcd_005_11cyc", 32'(bus.score_bcd), 32'h005);
    back_step(); idle(3);
    back_step(); idle(3);
    fwd_step();  idle(3);
    chk("score_after_back", 32'(bus.score), 32'd5);
    fwd_step(); idle(12);
    chk("score_pos5", 32'(bus.score), 32'd5);
    fwd_step(); idle(12);
    chk("score_pos6", 32'(bus.score), 32'd6);

    // Simultaneous fwd+back leaves pos alone (next fwd gives 7)
    bus.step_fwd  = 1'b1;
    bus.step_back = 1'b1;
    tick();
    bus.step_fwd  = 1'b0;
    bus.step_back = 1'b0;
    idle(12);
    chk("score_both", 32'(bus.score), 32'd6);
    fwd_step(); idle(12);
    chk("score_pos7", 32'(bus.score), 32'd7);

    repeat (7) begin
      bus.coin_pick = 1'b1;
      tick();
      bus.coin_pick = 1'b0;
      tick();
    end
    chk("coin_7", 32'(bus.coin), 32'd7);

    // Saturation at 999
    for (int i = 0; i < 1200; i++) begin
      fwd_step();
      idle(12);
    end
    chk("score_sat", 32'(bus.score), 32'd999);
    chk("bcd_999", 32'(bus.score_bcd), 32'h999);
    chk("bcd_valid_999", 32'(bus.bcd_valid), 32'd1);

    // Death held 100 cycles: credited once
    bus.game_state = 3'd2;
    idle(100);
    chk("death_store", 32'(bus.coin_store), 32'd7);
    chk("death_best", 32'(bus.best), 32'd999);
    bus.step_back = 1'b1;
    bus.coin_pick = 1'b1;
    tick();
    bus.step_back = 1'b0;
    bus.coin_pick = 1'b0;
    tick();
    chk("dead_score_kept", 32'(bus.score), 32'd999);
    chk("dead_coin_kept", 32'(bus.coin), 32'd7);

    // New run
    bus.game_state = 3'd1;
    tick();
    m_pos = 0;
    m_score = 0;
    bcd_q.push_back(12'h000);
    chk("run2_score", 32'(bus.score), 32'd0);
    chk("run2_coin", 32'(bus.coin), 32'd0);
    chk("run2_best", 32'(bus.best), 32'd999);
    chk("run2_store", 32'(bus.coin_store), 32'd7);
    idle(14);

    // Purchases from menu
    bus.game_state = 3'd0;
    tick();
    buy_q.push_back('{ack: 1'b1, store: 10'd2});
    buy(10'd5, 20);
    chk("buy1_store", 32'(bus.coin_store), 32'd2);
    buy_q.push_back('{ack: 1'b0, store: 10'd2});
    buy(10'd5, 20);
    chk("buy2_store", 32'(bus.coin_store), 32'd2);
    buy_q.push_back('{ack: 1'b1, store: 10'd0});
    buy(10'd2, 5);
    chk("buy3_store", 32'(bus.coin_store), 32'd0);

    // Request while playing is ignored; state 5 decodes as menu
    bus.game_state = 3'd1;
    tick();
    buy(10'd0, 10);
    bus.game_state = 3'd5;
    tick();
    buy_q.push_back('{ack: 1'b1, store: 10'd0});
    buy(10'd0, 5);

    // Reset in the middle of a conversion
    bus.game_state = 3'd1;
    tick();
    fwd_step();
    idle(4);
    chk("mid_conv_valid", 32'(bus.bcd_valid), 32'd0);
    rst = 1'b1;
    bcd_q.delete();
    m_pos = 0;
    m_score = 0;
    #1;
    chk("rst2_score", 32'(bus.score), 32'd0);
    chk("rst2_best", 32'(bus.best), 32'd0);
    chk("rst2_store", 32'(bus.coin_store), 32'd0);
    chk("rst2_bcd", 32'(bus.score_bcd), 32'h000);
    chk("rst2_bcd_valid", 32'(bus.bcd_valid), 32'd1);
    tick();
    rst = 1'b0;
    idle(15);
    chk("post_rst_bcd_valid", 32'(bus.bcd_valid), 32'd1);
    chk("post_rst_score", 32'(bus.score), 32'd0);

    idle(5);
    chk("buy_queue_drained", 32'(buy_q.size()), 32'd0);
    chk("bcd_queue_drained", 32'(bcd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
